// File: rtl/fan_pkg.sv
// Shared definitions for the fan off-timer: state encodings, preset one-hot
// codes, preset lengths in minutes and the preset-to-ticks helper.
package fan_pkg;

    typedef enum logic [1:0] {
        T_OFF    = 2'd0,
        T_COUNT  = 2'd1,
        T_EXPIRE = 2'd2
    } timer_state_t;

    localparam int REMAIN_W = 13;
    localparam int SEL_W    = 4;

    localparam logic [SEL_W-1:0] SEL_OFF = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_30  = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_60  = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_120 = 4'b1000;

    localparam int PRESET_30_MIN  = 30;
    localparam int PRESET_60_MIN  = 60;
    localparam int PRESET_120_MIN = 120;

    // Ticks to load for a preset; 120 min at 60 ticks/min is 7200, inside 13 bits.
    function automatic logic [REMAIN_W-1:0] preset_secs(input int minutes, input int min_secs);
        return REMAIN_W'(minutes * min_secs);
    endfunction

endpackage

// File: rtl/fan_off_timer_if.sv
// Signal bundle between the fan speed controller and the off-timer.
interface fan_off_timer_if;
    import fan_pkg::*;

    // No valid/ready here: btn_timer is a one-cycle request pulse the timer
    // always accepts (or ignores by rule), set_idle is a one-cycle command
    // the controller must act on, the rest are levels.
    logic                btn_timer;
    logic                fan_run;
    logic [SEL_W-1:0]    timer_sel;
    logic [REMAIN_W-1:0] remain_sec;
    logic                set_idle;
    logic                counting;

    modport master (
        output btn_timer,
        output fan_run,
        input  timer_sel,
        input  remain_sec,
        input  set_idle,
        input  counting
    );

    modport slave (
        input  btn_timer,
        input  fan_run,
        output timer_sel,
        output remain_sec,
        output set_idle,
        output counting
    );

endinterface

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..SEC_CYCLES-1 while enabled and pulses tick
// on the last count; clear has priority and returns the count to zero.
module sec_tick_gen #(
    parameter int SEC_CYCLES = 125_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SEC_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Not gated by clear: the consumer decides whether a reload beats the wrap.
    assign tick = enable & w_wrap;

endmodule

// File: rtl/fan_off_timer.sv
// Fan off-timer: a button cycles OFF/30/60/120 minute presets while the fan
// runs, counts the preset down in one-second ticks and pulses set_idle at expiry.
module fan_off_timer
    import fan_pkg::*;
#(
    parameter int SYS_FREQ   = 125,
    parameter int SEC_CYCLES = SYS_FREQ * 1_000_000,
    parameter int MIN_SECS   = 60
) (
    input  logic           clk,
    input  logic           reset_n,
    fan_off_timer_if.slave tmr,
    output timer_state_t   o_dbg_state
);

    timer_state_t        r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [REMAIN_W-1:0] r_remain;
    logic                r_set_idle;

    timer_state_t        w_state_nx;
    logic [SEL_W-1:0]    w_sel_nx;
    logic [REMAIN_W-1:0] w_remain_nx;
    logic                w_set_idle_nx;
    logic                w_clear;
    logic                w_tick;
    logic                w_last_sec;

    sec_tick_gen #(
        .SEC_CYCLES (SEC_CYCLES)
    ) u_sec_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (r_state == T_COUNT),
        .clear   (w_clear),
        .tick    (w_tick)
    );

    assign w_last_sec = (r_remain <= REMAIN_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= T_OFF;
            r_sel      <= SEL_OFF;
            r_remain   <= '0;
            r_set_idle <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_sel      <= w_sel_nx;
            r_remain   <= w_remain_nx;
            r_set_idle <= w_set_idle_nx;
        end
    end

    // Priority inside T_COUNT: fan stop cancels, then expiry, then the button, then the tick.
    always_comb begin
        w_state_nx  = r_state;
        w_sel_nx    = r_sel;
        w_remain_nx = r_remain;
        w_clear     = 1'b0;
        case (r_state)
            T_OFF: begin
                w_clear = 1'b1;
                if (tmr.fan_run && tmr.btn_timer) begin
                    w_state_nx  = T_COUNT;
                    w_sel_nx    = SEL_30;
                    w_remain_nx = preset_secs(PRESET_30_MIN, MIN_SECS);
                end
            end
            T_COUNT: begin
                if (!tmr.fan_run) begin
                    w_state_nx  = T_OFF;
                    w_sel_nx    = SEL_OFF;
                    w_remain_nx = '0;
                    w_clear     = 1'b1;
                end else if (w_tick && w_last_sec) begin
                    w_state_nx  = T_EXPIRE;
                    w_remain_nx = '0;
                end else if (tmr.btn_timer) begin
                    w_clear = 1'b1;
                    case (r_sel)
                        SEL_30: begin
                            w_sel_nx    = SEL_60;
                            w_remain_nx = preset_secs(PRESET_60_MIN, MIN_SECS);
                        end
                        SEL_60: begin
                            w_sel_nx    = SEL_120;
                            w_remain_nx = preset_secs(PRESET_120_MIN, MIN_SECS);
                        end
                        default: begin
                            w_state_nx  = T_OFF;
                            w_sel_nx    = SEL_OFF;
                            w_remain_nx = '0;
                        end
                    endcase
                end else if (w_tick) begin
                    w_remain_nx = r_remain - REMAIN_W'(1);
                end
            end
            T_EXPIRE: begin
                w_state_nx  = T_OFF;
                w_sel_nx    = SEL_OFF;
                w_remain_nx = '0;
                w_clear     = 1'b1;
            end
            default: begin
                w_state_nx  = T_OFF;
                w_sel_nx    = SEL_OFF;
                w_remain_nx = '0;
                w_clear     = 1'b1;
            end
        endcase
        w_set_idle_nx = (w_state_nx == T_EXPIRE);
    end

    assign tmr.timer_sel  = r_sel;
    assign tmr.remain_sec = r_remain;
    assign tmr.set_idle   = r_set_idle;
    assign tmr.counting   = (r_state == T_COUNT);
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fan_off_timer.sv
// Randomised and directed bench for fan_off_timer against an elapsed-time model.
module tb_fan_off_timer;
    import fan_pkg::*;

    localparam int SEC  = 10;
    localparam int MINS = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    timer_state_t dbg_state;

    fan_off_timer_if tb_if();

    fan_off_timer #(
        .SYS_FREQ   (1),
        .SEC_CYCLES (SEC),
        .MIN_SECS   (MINS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tmr         (tb_if),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_idle  = 0;

    // Model: preset index (0 off, 1..3 = 30/60/120 min), load edge, total ticks.
    int m_idx   = 0;
    int m_total = 0;
    int m_load  = 0;
    int m_cyc   = 0;
    bit m_exp   = 1'b0;

    logic [20:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_remain();
        return m_total - (m_cyc - m_load) / SEC;
    endfunction

    function automatic logic [20:0] model_vec();
        timer_state_t st;
        logic [3:0]   sel;
        logic [12:0]  rem;
        st  = m_exp ? T_EXPIRE : ((m_idx != 0) ? T_COUNT : T_OFF);
        sel = (m_idx == 0) ? 4'b0001 : 4'(1 << m_idx);
        rem = (m_idx == 0 || m_exp) ? 13'd0 : 13'(m_remain());
        return {st, sel, rem, m_exp, (m_idx != 0 && !m_exp)};
    endfunction

    task automatic model_step(input bit btn, input bit fan);
        m_cyc++;
        if (m_exp) begin
            m_exp = 1'b0;
            m_idx = 0;
        end else if (m_idx == 0) begin
            if (fan && btn) begin
                m_idx   = 1;
                m_total = 30 * MINS;
                m_load  = m_cyc;
            end
        end else if (!fan) begin
            m_idx = 0;
        end else if (m_cyc - m_load == m_total * SEC) begin
            m_exp = 1'b1;
        end else if (btn) begin
            if (m_idx == 3) begin
                m_idx = 0;
            end else begin
                m_idx++;
                m_total = (30 << (m_idx - 1)) * MINS;
                m_load  = m_cyc;
            end
        end
        exp_q.push_back(model_vec());
    endtask

    task automatic compare_outputs();
        logic [20:0] e;
        if (exp_q.size() == 0) begin
            check("exp_queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("state", dbg_state, e[20:19]);
        check("timer_sel", tb_if.timer_sel, e[18:15]);
        check("remain_sec", tb_if.remain_sec, e[14:2]);
        check("set_idle", tb_if.set_idle, e[1]);
        check("counting", tb_if.counting, e[0]);
        if (tb_if.set_idle === 1'b1) n_idle++;
    endtask

    task automatic tick_cycle(input bit btn, input bit fan);
        @(negedge clk);
        compare_outputs();
        tb_if.btn_timer = btn;
        tb_if.fan_run   = fan;
        model_step(btn, fan);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, dbg_state, T_OFF);
        check({tag, "_sel"}, tb_if.timer_sel, 4'b0001);
        check({tag, "_remain"}, tb_if.remain_sec, 0);
        check({tag, "_idle"}, tb_if.set_idle, 0);
        check({tag, "_counting"}, tb_if.counting, 0);
    endtask

    // Reset lands between clock edges so the check sees the asynchronous path.
    task automatic pulse_reset();
        @(negedge clk);
        compare_outputs();
        #2;
        reset_n = 1'b0;
        tb_if.btn_timer = 1'b0;
        #1;
        check_reset_vals("async_rst");
        if (tb_if.set_idle === 1'b1) n_idle++;
        m_idx = 0;
        m_exp = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("hold_rst");
        reset_n = 1'b1;
        model_step(1'b0, tb_if.fan_run);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int p;
        int len;
        tb_if.btn_timer = 1'b0;
        tb_if.fan_run   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        reset_n = 1'b1;
        model_step(1'b0, 1'b0);

        // Button pulses with the fan stopped are ignored.
        for (int i = 0; i < 20; i++) tick_cycle(i % 4 == 0, 1'b0);
        check("fan_off_sel", tb_if.timer_sel, 4'b0001);

        // Single 30-minute countdown to expiry.
        base = n_idle;
        tick_cycle(1'b1, 1'b1);
        tick_cycle(1'b0, 1'b1);
        check("s1_remain_loaded", tb_if.remain_sec, 60);
        check("s1_sel_30", tb_if.timer_sel, 4'b0010);
        repeat (605) tick_cycle(1'b0, 1'b1);
        check("s1_idle_pulses", n_idle - base, 1);
        check("s1_sel_off", tb_if.timer_sel, 4'b0001);

        // Preset walk 30 -> 60 -> 120 -> OFF.
        base = n_idle;
        tick_cycle(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            repeat (4) tick_cycle(1'b0, 1'b1);
            tick_cycle(1'b1, 1'b1);
        end
        repeat (3) tick_cycle(1'b0, 1'b1);
        check("s2_sel_off", tb_if.timer_sel, 4'b0001);
        check("s2_no_idle", n_idle - base, 0);

        // Fan stops mid-countdown at 37 ticks remaining.
        base = n_idle;
        tick_cycle(1'b1, 1'b1);
        for (int i = 0; i < 2000 && m_remain() != 37; i++) tick_cycle(1'b0, 1'b1);
        check("s3_reached_37", m_remain(), 37);
        tick_cycle(1'b0, 1'b0);
        tick_cycle(1'b0, 1'b0);
        check("s3_remain_zero", tb_if.remain_sec, 0);
        repeat (1000) tick_cycle(1'b0, 1'b0);
        check("s3_no_idle", n_idle - base, 0);

        // Button lands on the final wrap: expiry wins.
        base = n_idle;
        tick_cycle(1'b1, 1'b1);
        for (int i = 0; i < 2000 && (m_cyc + 1 - m_load != m_total * SEC); i++)
            tick_cycle(1'b0, 1'b1);
        check("s4_aligned", m_cyc + 1 - m_load, m_total * SEC);
        tick_cycle(1'b1, 1'b1);
        repeat (5) tick_cycle(1'b0, 1'b1);
        check("s4_idle_pulses", n_idle - base, 1);
        check("s4_sel_off", tb_if.timer_sel, 4'b0001);

        // Reset at 20 ticks remaining, then a fresh start.
        base = n_idle;
        tick_cycle(1'b1, 1'b1);
        for (int i = 0; i < 2000 && m_remain() != 20; i++) tick_cycle(1'b0, 1'b1);
        check("s5_reached_20", m_remain(), 20);
        pulse_reset();
        repeat (10) tick_cycle(1'b0, 1'b1);
        check("s5_no_idle", n_idle - base, 0);
        tick_cycle(1'b1, 1'b1);
        tick_cycle(1'b0, 1'b1);
        check("s5_restart_remain", tb_if.remain_sec, 60);

        // Random segments with varying button density and rare fan drops.
        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 2))
                0:       p = 0;
                1:       p = 3;
                default: p = 30;
            endcase
            len = $urandom_range(50, 700);
            tick_cycle(1'b1, 1'b1);
            for (int i = 0; i < len; i++)
                tick_cycle($urandom_range(0, 999) < p, $urandom_range(0, 1499) != 0);
            if (seg % 13 == 12) pulse_reset();
        end
        @(negedge clk);
        compare_outputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fan_off_timer.md
FAN_OFF_TIMER -- requirements
Module: fan_off_timer

Interface
REQ-001 The block SHALL provide parameter SYS_FREQ, default 125, system clock frequency in MHz.
REQ-002 The block SHALL provide parameter SEC_CYCLES, default SYS_FREQ*1_000_000, clock cycles per one-second tick.
REQ-003 The block SHALL provide parameter MIN_SECS, default 60, ticks per timer minute (legal range 1..60).
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low, with ports named as follows.
REQ-005 clk  input  1  system clock; all logic on posedge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 btn_timer  input  1  debounced single-cycle pulse that advances the timer preset.
REQ-008 fan_run  input  1  high while the fan runs at any non-idle speed.
REQ-009 timer_sel  output  4  one-hot preset: bit0 OFF, bit1 30 min, bit2 60 min, bit3 120 min.
REQ-010 remain_sec  output  13  remaining ticks until expiry; 0 when not counting.
REQ-011 set_idle  output  1  single-cycle pulse commanding the fan to stop.
REQ-012 counting  output  1  high while a countdown is active.

Function
REQ-013 The FSM SHALL have states T_OFF, T_COUNT and T_EXPIRE.
REQ-014 In T_OFF with fan_run=1, a btn_timer pulse SHALL select the 30-min preset, load remain_sec=30*MIN_SECS, clear the prescaler and enter T_COUNT on the next cycle.
REQ-015 In T_COUNT, a btn_timer pulse SHALL advance the preset 30→60→120→OFF, reload remain_sec with preset*MIN_SECS and clear the prescaler; advancing to OFF SHALL clear remain_sec and enter T_OFF.
REQ-016 btn_timer SHALL be ignored while fan_run=0.
REQ-017 The prescaler SHALL count 0..SEC_CYCLES-1 only in T_COUNT, and its wrap SHALL decrement remain_sec by 1.
REQ-018 A wrap with remain_sec=1 SHALL set remain_sec=0 and enter T_EXPIRE.
REQ-019 T_EXPIRE SHALL last exactly one cycle, drive set_idle=1, then set timer_sel=OFF and enter T_OFF.
REQ-020 If fan_run falls in T_COUNT, the timer SHALL return to T_OFF with timer_sel=OFF and remain_sec=0 on the next cycle, and set_idle SHALL NOT be asserted.
REQ-021 Simultaneous expiry wrap and btn_timer SHALL resolve with expiry taking priority and the button ignored.
REQ-022 Simultaneous fan_run fall and btn_timer SHALL resolve with the cancel taking priority.
REQ-023 set_idle SHALL be registered, and SHALL never stay high for more than one cycle.
REQ-024 counting SHALL equal 1 exactly when state is T_COUNT.
REQ-025 remain_sec SHALL never underflow or wrap; 120*MIN_SECS ≤ 7200 fits 13 bits.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately force T_OFF, timer_sel=4'b0001, remain_sec=0, set_idle=0, counting=0 and prescaler=0.
REQ-027 Reset asserted mid-countdown SHALL abort the countdown with no set_idle pulse.
REQ-028 After release, the first btn_timer pulse with fan_run=1 SHALL behave as in REQ-014.

Structure
REQ-029 The shared package fan_pkg SHALL hold the state encodings, the timer_sel one-hot constants and the preset minutes (30/60/120).
REQ-030 The one-second prescaler SHALL be a sub-module named sec_tick_gen with inputs clk, reset_n, enable and clear, and output tick as a one-cycle pulse.
REQ-031 set_idle SHALL connect directly to the fan speed controller's set_idle input, and fan_run SHALL be driven from that controller's run indicator.

Verification (SEC_CYCLES=10, MIN_SECS=2)
REQ-032 Scenario: fan_run=1, one btn_timer pulse → timer_sel=0010, remain_sec=60, counting=1; 600 cycles later a one-cycle set_idle pulse, then timer_sel=0001 and remain_sec=0.
REQ-033 Scenario: four btn_timer pulses spaced 5 cycles apart → remain_sec sequence 60, 120, 240, 0, ending with timer_sel=0001 and no set_idle.
REQ-034 Scenario: countdown at remain_sec=37, fan_run falls → next cycle T_OFF, remain_sec=0, and no set_idle for 1000 cycles.
REQ-035 Scenario: btn_timer pulses while fan_run=0 → outputs hold their reset values.
REQ-036 Scenario: btn_timer in the same cycle as the final wrap (remain_sec 1→0) → set_idle pulses once, timer_sel=0001, and the button is discarded.
REQ-037 Scenario: reset_n pulsed low at remain_sec=20 → all outputs reset asynchronously, with no set_idle at any point.
